// File: rtl/dmem_burst_if.sv
// Request/write/read streams plus the Data_Memory address/data/RW bus for dmem_burst_master.
// The err signal exists only when DMEM_BURST_BOUNDS_EN is defined.
interface dmem_burst_if #(
   parameter int AW  = 8,
   parameter int DW  = 8,
   parameter int RDW = 17
);
   logic           req_valid;
   logic           req_ready;
   logic           req_write;
   logic [AW-1:0]  req_addr;
   logic [AW-1:0]  req_len;
   logic [DW-1:0]  wr_data;
   logic           wr_valid;
   logic           wr_ready;
   logic [RDW-1:0] rd_data;
   logic           rd_valid;
   logic           busy;
   logic           done;
   logic [AW-1:0]  mem_addr;
   logic [DW-1:0]  mem_din;
   logic           mem_rw;
   logic [RDW-1:0] mem_dout;
`ifdef DMEM_BURST_BOUNDS_EN
   logic           err;
`endif

   modport master (
      input  req_valid, req_write, req_addr, req_len, wr_data, wr_valid, mem_dout,
      output req_ready, wr_ready, rd_data, rd_valid, busy, done, mem_addr, mem_din, mem_rw
`ifdef DMEM_BURST_BOUNDS_EN
      , output err
`endif
   );

   modport slave (
      output req_valid, req_write, req_addr, req_len, wr_data, wr_valid, mem_dout,
      input  req_ready, wr_ready, rd_data, rd_valid, busy, done, mem_addr, mem_din, mem_rw
`ifdef DMEM_BURST_BOUNDS_EN
      , input err
`endif
   );
endinterface

// File: rtl/dmem_burst_master.sv
// Burst load/store initiator for Data_Memory; all outputs registered.
// DMEM_BURST_BOUNDS_EN: reject bursts crossing the top of the address space (err + done, no access).
//   IDLE     | ready for a request
//   WR_WAIT  | waiting for a store beat on wr_valid
//   WR_PULSE | mem_rw high for one cycle
//   RD_WAIT  | address stable, waiting RD_LAT cycles
//   RD_CAP   | capture mem_dout, strobe rd_valid
//   DONE     | done strobe, back to IDLE next
module dmem_burst_master #(
   parameter int AW     = 8,
   parameter int DW     = 8,
   parameter int RDW    = 17,
   parameter int RD_LAT = 1
) (
   input  logic         clk,
   input  logic         rst,
   dmem_burst_if.master bus
);

   typedef enum logic [2:0] {IDLE, WR_WAIT, WR_PULSE, RD_WAIT, RD_CAP, DONE} state_t;

   localparam logic [1:0] TMR_INIT = 2'(RD_LAT - 1);

   state_t         state_q, state_d;
   logic [AW-1:0]  cur_addr_q, cur_addr_d;
   logic [AW-1:0]  cnt_q, cnt_d;
   logic [1:0]     tmr_q, tmr_d;
   logic           req_ready_q, req_ready_d;
   logic           busy_q, busy_d;
   logic           wr_ready_q, wr_ready_d;
   logic [RDW-1:0] rd_data_q, rd_data_d;
   logic           rd_valid_q, rd_valid_d;
   logic           done_q, done_d;
   logic [AW-1:0]  mem_addr_q, mem_addr_d;
   logic [DW-1:0]  mem_din_q, mem_din_d;
   logic           mem_rw_q, mem_rw_d;
   logic           oob;

`ifdef DMEM_BURST_BOUNDS_EN
   logic           err_q, err_d;
   logic [AW:0]    end_addr;

   assign end_addr = {1'b0, bus.req_addr} + {1'b0, bus.req_len};
   assign oob      = end_addr[AW];
`else
   assign oob      = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      cur_addr_d  = cur_addr_q;
      cnt_d       = cnt_q;
      tmr_d       = tmr_q;
      req_ready_d = req_ready_q;
      busy_d      = busy_q;
      wr_ready_d  = wr_ready_q;
      rd_data_d   = rd_data_q;
      rd_valid_d  = 1'b0;
      done_d      = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_din_d   = mem_din_q;
      mem_rw_d    = 1'b0;
`ifdef DMEM_BURST_BOUNDS_EN
      err_d       = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               cur_addr_d  = bus.req_addr;
               cnt_d       = bus.req_len;
               req_ready_d = 1'b0;
               busy_d      = 1'b1;
               if (oob) begin
                  state_d = DONE;
                  done_d  = 1'b1;
`ifdef DMEM_BURST_BOUNDS_EN
                  err_d   = 1'b1;
`endif
               end else if (bus.req_write) begin
                  state_d    = WR_WAIT;
                  wr_ready_d = 1'b1;
               end else begin
                  state_d    = RD_WAIT;
                  mem_addr_d = bus.req_addr;
                  tmr_d      = TMR_INIT;
               end
            end
         end
         WR_WAIT: begin
            if (bus.wr_valid) begin
               state_d    = WR_PULSE;
               wr_ready_d = 1'b0;
               mem_addr_d = cur_addr_q;
               mem_din_d  = bus.wr_data;
               mem_rw_d   = 1'b1;
            end
         end
         WR_PULSE: begin
            // mem_addr/mem_din keep their values past the pulse for hold time
            cur_addr_d = cur_addr_q + AW'(1);
            if (cnt_q == '0) begin
               state_d = DONE;
               done_d  = 1'b1;
            end else begin
               cnt_d      = cnt_q - AW'(1);
               state_d    = WR_WAIT;
               wr_ready_d = 1'b1;
            end
         end
         RD_WAIT: begin
            if (tmr_q == '0) state_d = RD_CAP;
            else             tmr_d   = tmr_q - 2'd1;
         end
         RD_CAP: begin
            rd_data_d  = bus.mem_dout;
            rd_valid_d = 1'b1;
            cur_addr_d = cur_addr_q + AW'(1);
            if (cnt_q == '0) begin
               state_d = DONE;
               done_d  = 1'b1;
            end else begin
               cnt_d      = cnt_q - AW'(1);
               state_d    = RD_WAIT;
               mem_addr_d = cur_addr_q + AW'(1);
               tmr_d      = TMR_INIT;
            end
         end
         DONE: begin
            state_d     = IDLE;
            busy_d      = 1'b0;
            req_ready_d = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cur_addr_q  <= '0;
         cnt_q       <= '0;
         tmr_q       <= '0;
         req_ready_q <= 1'b1;
         busy_q      <= 1'b0;
         wr_ready_q  <= 1'b0;
         rd_data_q   <= '0;
         rd_valid_q  <= 1'b0;
         done_q      <= 1'b0;
         mem_addr_q  <= '0;
         mem_din_q   <= '0;
         mem_rw_q    <= 1'b0;
`ifdef DMEM_BURST_BOUNDS_EN
         err_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cur_addr_q  <= cur_addr_d;
         cnt_q       <= cnt_d;
         tmr_q       <= tmr_d;
         req_ready_q <= req_ready_d;
         busy_q      <= busy_d;
         wr_ready_q  <= wr_ready_d;
         rd_data_q   <= rd_data_d;
         rd_valid_q  <= rd_valid_d;
         done_q      <= done_d;
         mem_addr_q  <= mem_addr_d;
         mem_din_q   <= mem_din_d;
         mem_rw_q    <= mem_rw_d;
`ifdef DMEM_BURST_BOUNDS_EN
         err_q       <= err_d;
`endif
      end
   end

   assign bus.req_ready = req_ready_q;
   assign bus.busy      = busy_q;
   assign bus.wr_ready  = wr_ready_q;
   assign bus.rd_data   = rd_data_q;
   assign bus.rd_valid  = rd_valid_q;
   assign bus.done      = done_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_din   = mem_din_q;
   assign bus.mem_rw    = mem_rw_q;
`ifdef DMEM_BURST_BOUNDS_EN
   assign bus.err       = err_q;
`endif

endmodule

// File: tb/tb_dmem_burst_master.sv
// Bench for dmem_burst_master: directed bursts, stall, ignored request, mid-burst reset, random bursts.
module tb_dmem_burst_master;
   localparam int AW = 8, DW = 8, RDW = 17, RD_LAT = 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0, n_chk = 0, n_err = 0, n_done = 0, rw_dbl = 0;

   dmem_burst_if #(.AW(AW), .DW(DW), .RDW(RDW)) bus ();
   dmem_burst_master #(.AW(AW), .DW(DW), .RDW(RDW), .RD_LAT(RD_LAT)) dut (
      .clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;
   initial forever begin @(posedge clk); cyc++; end

   // reference memory contents, kept by the bench from the request rules
   logic [RDW-1:0] refmem [256];
   // environment memory, written and read by the DUT
   logic [RDW-1:0] mem    [256];
   logic [RDW-1:0] rpipe  [RD_LAT];
   assign bus.mem_dout = rpipe[RD_LAT-1];
   initial begin
      #1;
      for (int i = 0; i < 256; i++) mem[i] = refmem[i];
      forever begin
         @(posedge clk);
         if (bus.mem_rw) mem[bus.mem_addr] <= RDW'(bus.mem_din);
         rpipe[0] <= mem[bus.mem_addr];
         for (int i = 1; i < RD_LAT; i++) rpipe[i] <= rpipe[i-1];
      end
   end

   logic [AW-1:0]  wq_addr [$];
   logic [DW-1:0]  wq_data [$];
   logic [RDW-1:0] rq      [$];
   int             rcq     [$];
`ifdef DMEM_BURST_BOUNDS_EN
   logic           err_at_done;
`endif

   initial begin
      bit prev_rw;
      prev_rw = 1'b0;
      forever begin
         @(posedge clk); #2;
         if (bus.done) n_done++;
         if (rst) prev_rw = 1'b0;
         else begin
            if (bus.mem_rw) begin
               wq_addr.push_back(bus.mem_addr);
               wq_data.push_back(bus.mem_din);
               if (prev_rw) rw_dbl++;
            end
            prev_rw = bus.mem_rw;
            if (bus.rd_valid) begin
               rq.push_back(bus.rd_data);
               rcq.push_back(cyc);
            end
         end
      end
   end

   // store-beat driver
   logic [DW-1:0] wdq [$];
   bit wr_rnd = 1'b0;
   int stall_idx = -1, stall_left = 0, beat_idx = 0;
   initial begin
      bit hs_pend;
      logic [DW-1:0] dummy;
      hs_pend = 1'b0;
      bus.wr_valid = 1'b0;
      bus.wr_data  = '0;
      forever begin
         @(negedge clk);
         if (hs_pend && wdq.size() > 0) begin
            dummy = wdq.pop_front();
            beat_idx++;
         end
         if (wdq.size() == 0) bus.wr_valid = 1'b0;
         else if (beat_idx == stall_idx && stall_left > 0 && bus.wr_ready) begin
            bus.wr_valid = 1'b0;
            stall_left--;
         end else bus.wr_valid = wr_rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
         bus.wr_data = (wdq.size() > 0) ? wdq[0] : '0;
         hs_pend = bus.wr_valid && bus.wr_ready;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", n_chk, n_err);
      $fatal(1, "watchdog");
   end

   task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk); #2;
   endtask

   task automatic do_req(input bit wr, input logic [AW-1:0] a, input logic [AW-1:0] len,
                         output int acc);
      int n;
      n = 0;
      while (!bus.req_ready && n < 200) begin tick(); n++; end
      chk_val("req_ready_wait", bus.req_ready, 1);
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_write = wr;
      bus.req_addr  = a;
      bus.req_len   = len;
      tick();
      acc = cyc;
      @(negedge clk);
      bus.req_valid = 1'b0;
   endtask

   task automatic wait_done(output int dc);
      dc = -1;
      for (int n = 0; n < 400 && dc < 0; n++) begin
         tick();
         if (bus.done) begin
            dc = cyc;
`ifdef DMEM_BURST_BOUNDS_EN
            err_at_done = bus.err;
`endif
         end
      end
      chk_val("done_seen", 32'(dc >= 0), 1);
   endtask

   task automatic run_burst(input bit wr, input logic [AW-1:0] a, input logic [AW-1:0] len,
                            input bit timed);
      logic [DW-1:0] exp_d [$];
      int acc, dc, d0, beats, idx, last;
      bit oob;
      exp_d = wdq;
      beat_idx = 0;
      wq_addr.delete(); wq_data.delete(); rq.delete(); rcq.delete();
      rw_dbl = 0;
      d0 = n_done;
      oob = 1'b0;
      last = 0;
`ifdef DMEM_BURST_BOUNDS_EN
      oob = (int'(a) + int'(len)) > 255;
`endif
      beats = oob ? 0 : int'(len) + 1;
      do_req(wr, a, len, acc);
      wait_done(dc);
      tick();
      chk_val("req_ready_after_done", bus.req_ready, 1);
      chk_val("busy_after_done", bus.busy, 0);
      chk_val("done_strobes", n_done - d0, 1);
      if (timed)
         chk_val("done_latency", dc - acc, oob ? 1 : (wr ? 2 * beats : beats * (RD_LAT + 1)));
`ifdef DMEM_BURST_BOUNDS_EN
      chk_val("err_at_done", err_at_done, oob);
`endif
      chk_val("write_count", wq_addr.size(), wr ? beats : 0);
      chk_val("read_count", rq.size(), wr ? 0 : beats);
      for (int k = 0; k < beats; k++) begin
         idx = (int'(a) + k) % 256;
         if (wr) begin
            if (k < wq_addr.size()) begin
               chk_val("write_addr", wq_addr[k], idx);
               chk_val("write_data", wq_data[k], exp_d[k]);
            end
            refmem[idx] = RDW'(exp_d[k]);
         end else begin
            if (k < rq.size()) begin
               chk_val("read_data", rq[k], refmem[idx]);
               chk_val("read_cycle", rcq[k] - acc, (k + 1) * (RD_LAT + 1));
            end
            last = idx;
         end
      end
      if (!wr && beats > 0) chk_val("rd_data_hold", bus.rd_data, refmem[last]);
      chk_val("mem_rw_single_cycle", rw_dbl, 0);
      wdq.delete();
   endtask

   initial begin
      int acc, d0, n_stall;
      bit found, rwr;
      logic [AW-1:0] ra, rl;
      logic [DW-1:0] rst_d [$];

      for (int i = 0; i < 256; i++) refmem[i] = RDW'($urandom);
      bus.req_valid = 1'b0;
      bus.req_write = 1'b0;
      bus.req_addr  = '0;
      bus.req_len   = '0;

      repeat (2) tick();
      chk_val("reset_req_ready", bus.req_ready, 1);
      chk_val("reset_outputs", {bus.busy, bus.done, bus.wr_ready, bus.rd_valid, bus.mem_rw}, 0);
      chk_val("reset_buses", {bus.mem_addr, bus.mem_din, bus.rd_data}, 0);
`ifdef DMEM_BURST_BOUNDS_EN
      chk_val("reset_err", bus.err, 0);
`endif
      @(negedge clk) rst = 1'b0;

      // store 0,2..14 to 0..7 with wr_valid held, then read it back
      for (int i = 0; i < 8; i++) wdq.push_back(DW'(2 * i));
      run_burst(1'b1, 8'h00, 8'd7, 1'b1);
      run_burst(1'b0, 8'h00, 8'd7, 1'b1);

      // store across the top of the address space
      wdq.push_back(8'h0A); wdq.push_back(8'h0B); wdq.push_back(8'h0C);
      run_burst(1'b1, 8'hFE, 8'd2, 1'b1);

      // five-cycle wr_valid stall before beat 2
      for (int i = 0; i < 4; i++) wdq.push_back(DW'($urandom));
      stall_idx = 2; stall_left = 5; n_stall = 0;
      fork
         run_burst(1'b1, 8'h20, 8'd3, 1'b0);
         begin
            for (int n = 0; n < 40; n++) begin
               tick();
               if (!bus.wr_valid && wdq.size() > 0 && bus.busy) begin
                  n_stall++;
                  chk_val("stall_wr_ready", bus.wr_ready, 1);
                  chk_val("stall_mem_rw", bus.mem_rw, 0);
               end
            end
         end
      join
      chk_val("stall_cycles", n_stall, 5);
      stall_idx = -1;

      // competing request during a load is ignored
      fork
         run_burst(1'b0, 8'h10, 8'd7, 1'b1);
         begin
            repeat (4) tick();
            @(negedge clk);
            bus.req_valid = 1'b1; bus.req_write = 1'b1;
            bus.req_addr  = 8'h80; bus.req_len = 8'd0;
            for (int n = 0; n < 4; n++) begin
               tick();
               chk_val("busy_req_ready", bus.req_ready, 0);
            end
            @(negedge clk) bus.req_valid = 1'b0;
         end
      join

      // reset during the write pulse of beat 3
      for (int i = 0; i < 8; i++) wdq.push_back(DW'($urandom));
      rst_d = wdq;
      beat_idx = 0;
      d0 = n_done;
      do_req(1'b1, 8'h40, 8'd7, acc);
      found = 1'b0;
      for (int n = 0; n < 40 && !found; n++) begin
         tick();
         if (bus.mem_rw && bus.mem_addr == 8'h42) found = 1'b1;
      end
      chk_val("rst_reached_beat3", found, 1);
      #1 rst = 1'b1;
      #1;
      chk_val("rst_mem_rw", bus.mem_rw, 0);
      chk_val("rst_flags", {bus.busy, bus.done, bus.wr_ready, bus.rd_valid, bus.req_ready}, 1);
      chk_val("rst_buses", {bus.mem_addr, bus.mem_din}, 0);
      repeat (3) tick();
      @(negedge clk) rst = 1'b0;
      wdq.delete();
      refmem[8'h40] = RDW'(rst_d[0]);
      refmem[8'h41] = RDW'(rst_d[1]);
      repeat (2) tick();
      chk_val("rst_no_done", n_done - d0, 0);
      run_burst(1'b0, 8'h40, 8'd2, 1'b1);

      // random bursts, stores with random wr_valid gaps
      wr_rnd = 1'b1;
      for (int t = 0; t < 24; t++) begin
         rwr = 1'($urandom_range(0, 1));
         rl  = AW'($urandom_range(0, 15));
         ra  = ($urandom_range(0, 3) == 0) ? AW'(8'hF4 + $urandom_range(0, 11)) : AW'($urandom);
         if (rwr) for (int i = 0; i <= int'(rl); i++) wdq.push_back(DW'($urandom));
         run_burst(rwr, ra, rl, !rwr);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
